// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 padder and compression core.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int BLOCK_BYTES = BLOCK_W / 8;
  // First byte index of the trailing length field (56).
  localparam int LEN_POS     = (BLOCK_W - LEN_FIELD_W) / 8;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} pad_state_e;

  localparam logic [0:7][31:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha_pad_compose.sv
// Combinational block builder: pads a data block after byte p, or forms the
// trailing length-only block when tail_i is set.
module sha_pad_compose
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0]     buf_i,
  input  logic [6:0]             p_i,
  input  logic [LEN_FIELD_W-1:0] len_bits_i,
  input  logic                   tail_i,
  input  logic                   tail80_i,
  output logic [BLOCK_W-1:0]     blk_o
);

  logic len_here;

  always_comb begin
    len_here = tail_i || (p_i <= 7'(LEN_POS - 1));
    blk_o    = buf_i;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (tail_i)
        blk_o[BLOCK_W-1-8*i -: 8] = (i == 0 && tail80_i) ? PAD_BYTE : 8'h00;
      else if (7'(i) == p_i)
        blk_o[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
      else if (7'(i) > p_i)
        blk_o[BLOCK_W-1-8*i -: 8] = 8'h00;
      // Big-endian bit length occupies the last eight bytes when it fits.
      if (len_here && i >= LEN_POS)
        blk_o[BLOCK_W-1-8*i -: 8] = len_bits_i[LEN_FIELD_W-1-8*(i-LEN_POS) -: 8];
    end
  end

endmodule

// File: rtl/sha_stream_padder.sv
// Byte-stream to padded SHA-256 block front end.
// Define SHA_PADDER_OVF_EN to drop bytes past the length counter range and flag err_overflow.
module sha_stream_padder
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_last,
  output logic               err_overflow
);

  pad_state_e             state_q, state_d;
  logic [BLOCK_W-1:0]     buf_q, buf_d, buf_wr, cmp_blk;
  logic [6:0]             idx_q, idx_d, cmp_p;
  logic [MAX_BYTES_W-1:0] len_q, len_d, len_inc, cmp_len;
  logic                   last_q, last_d, tp_q, tp_d, t80_q, t80_d;
  logic                   drop, accept, blk_hs;

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;
  assign accept    = in_valid && in_ready;
  assign blk_hs    = blk_valid && blk_ready;

`ifdef SHA_PADDER_OVF_EN
  logic err_q;
  assign drop = (len_q == {MAX_BYTES_W{1'b1}});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_q <= 1'b0;
    else if (blk_hs && last_q && !tp_q) err_q <= 1'b0;
    else if (accept && drop)            err_q <= 1'b1;
  end
  assign err_overflow = err_q;
`else
  assign drop         = 1'b0;
  assign err_overflow = 1'b0;
`endif

  assign len_inc = drop ? len_q : len_q + 1'b1;

  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < BLOCK_BYTES; i++)
      if (idx_q[5:0] == 6'(i)) buf_wr[BLOCK_W-1-8*i -: 8] = in_data;
  end

  // In EMIT the composer builds the tail block from the stored length.
  assign cmp_p   = drop ? idx_q : idx_q + 7'd1;
  assign cmp_len = (state_q == EMIT) ? len_q : len_inc;

  sha_pad_compose u_compose (
    .buf_i      (drop ? buf_q : buf_wr),
    .p_i        (cmp_p),
    .len_bits_i (LEN_FIELD_W'({cmp_len, 3'b000})),
    .tail_i     (state_q == EMIT),
    .tail80_i   (t80_q),
    .blk_o      (cmp_blk)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    last_d  = last_q;
    tp_d    = tp_q;
    t80_d   = t80_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (!drop) begin
            buf_d = buf_wr;
            idx_d = idx_q + 7'd1;
            len_d = len_inc;
          end
          if (in_last) begin
            buf_d   = cmp_blk;
            state_d = EMIT;
            if (cmp_p <= 7'(LEN_POS - 1)) begin
              last_d = 1'b1;
            end else begin
              last_d = 1'b0;
              tp_d   = 1'b1;
              t80_d  = (cmp_p == 7'(BLOCK_BYTES));
            end
          end else if (!drop && idx_q == 7'(BLOCK_BYTES - 1)) begin
            state_d = EMIT;
            last_d  = 1'b0;
          end
        end
      end
      EMIT: begin
        if (blk_hs) begin
          if (tp_q) begin
            buf_d  = cmp_blk;
            last_d = 1'b1;
            tp_d   = 1'b0;
            t80_d  = 1'b0;
          end else begin
            state_d = FILL;
            buf_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            if (last_q) len_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      tp_q    <= 1'b0;
      t80_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      last_q  <= last_d;
      tp_q    <= tp_d;
      t80_q   <= t80_d;
    end
  end

endmodule

// File: tb/tb_sha_stream_padder.sv
// Directed scoreboard bench for sha_stream_padder; blocks are predicted by a FIPS 180-4 padding model.
module tb_sha_stream_padder;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_last, blk_valid, blk_ready, blk_last, err_overflow;
  logic [7:0]   in_data;
  logic [511:0] blk_data;

  logic         o_valid, o_inready, o_last, o_bvalid, o_ready, o_blast, o_err;
  logic [7:0]   o_data;
  logic [511:0] o_bdata;

  sha_stream_padder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .err_overflow(err_overflow)
  );

  sha_stream_padder #(.MAX_BYTES_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(o_valid), .in_ready(o_inready), .in_data(o_data),
    .in_last(o_last), .blk_valid(o_bvalid), .blk_ready(o_ready), .blk_data(o_bdata),
    .blk_last(o_blast), .err_overflow(o_err)
  );

  typedef struct {
    logic [511:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  byte unsigned msg[$];
  int           errors = 0;
  int           checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference padding: msg, 0x80, zeros to 56 mod 64, then 64-bit length.
  function automatic int model(input logic [63:0] lbits);
    byte unsigned pad[$];
    exp_t e;
    int nb;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pad.push_back(lbits[8*k +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = pad[64*b+j];
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
    return nb;
  endfunction

  // Scoreboard: whatever the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && blk_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_blk", {511'b0, blk_valid}, 512'd0);
      end else begin
        check("blk_data", blk_data, exp_q[0].data);
        check("blk_last", {511'b0, blk_last}, {511'b0, exp_q[0].last});
        check("in_ready_emit", {511'b0, in_ready}, 512'd0);
        if (blk_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input bit fin);
    int  i, cyc;
    bit  acc;
    i = 0; cyc = 0;
    while (i < msg.size() && cyc < 3000) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = fin && (i == msg.size() - 1);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (in_last || (i % 64) == 63) check("blk_latency", {511'b0, blk_valid}, 512'd1);
        i++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i != msg.size()) check("send_timeout", 512'(i), 512'(msg.size()));
  endtask

  task automatic drain(input int nblk, input int stall, input bit b2b);
    int cnt;
    for (int b = 0; b < nblk; b++) begin
      blk_ready = (stall == 0);
      if (b2b && b > 0) check("tail_no_bubble", {511'b0, blk_valid}, 512'd1);
      cnt = 0;
      while (!blk_valid && cnt < 2000) begin @(posedge clk); #1; cnt++; end
      check("blk_wait", {511'b0, blk_valid}, 512'd1);
      repeat (stall) begin @(posedge clk); #1; end
      blk_ready = 1'b1;
      @(posedge clk); #1;
    end
    blk_ready = 1'b0;
    check("in_ready_after", {511'b0, in_ready}, 512'd1);
    check("valid_after", {511'b0, blk_valid}, 512'd0);
  endtask

  task automatic run(input logic [63:0] lbits, input int stall, input bit b2b);
    int nb;
    nb = model(lbits);
    fork
      send(1'b1);
      drain(nb, stall, b2b);
    join
  endtask

  initial begin
    exp_t e;
    int   nb;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
    o_valid = 1'b0; o_data = 8'h00; o_last = 1'b0; o_ready = 1'b0;
    #12;
    check("rst_valid", {511'b0, blk_valid}, 512'd0);
    check("rst_data", blk_data, 512'd0);
    check("rst_last", {511'b0, blk_last}, 512'd0);
    check("rst_err", {511'b0, err_overflow}, 512'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("rst_in_ready", {511'b0, in_ready}, 512'd1);

    msg = {8'h61, 8'h62, 8'h63};
    run(64'd24, 0, 1'b0);

    msg.delete(); repeat (55) msg.push_back(8'h00);
    run(64'd440, 0, 1'b0);

    msg.delete(); repeat (56) msg.push_back(8'h41);
    run(64'd448, 0, 1'b1);

    msg.delete(); for (int k = 0; k < 64; k++) msg.push_back(8'(k * 3 + 1));
    run(64'd512, 0, 1'b1);

    msg.delete(); for (int k = 0; k < 130; k++) msg.push_back(8'(255 - k));
    run(64'd1040, 5, 1'b0);

    // Abandon a partially filled message with an asynchronous reset.
    msg.delete(); for (int k = 0; k < 10; k++) msg.push_back(8'(k + 16));
    send(1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {511'b0, blk_valid}, 512'd0);
    check("mid_rst_data", blk_data, 512'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("mid_rst_in_ready", {511'b0, in_ready}, 512'd1);
    msg = {8'h61, 8'h62, 8'h63};
    run(64'd24, 2, 1'b0);

    // 4-bit length counter instance: saturation with the overflow option, wrap without it.
    for (int k = 0; k < 17; k++) begin
      o_valid = 1'b1; o_data = 8'(k + 1); o_last = (k == 16);
      @(posedge clk); #1;
`ifdef SHA_PADDER_OVF_EN
      if (k == 14) check("ovf_flag_pre", {511'b0, o_err}, 512'd0);
      if (k == 15) check("ovf_flag_set", {511'b0, o_err}, 512'd1);
`else
      if (k == 15) check("ovf_flag_off", {511'b0, o_err}, 512'd0);
`endif
    end
    o_valid = 1'b0; o_last = 1'b0;
    check("ovf_blk_valid", {511'b0, o_bvalid}, 512'd1);
    msg.delete();
`ifdef SHA_PADDER_OVF_EN
    for (int k = 0; k < 15; k++) msg.push_back(8'(k + 1));
    nb = model(64'h78);
`else
    for (int k = 0; k < 17; k++) msg.push_back(8'(k + 1));
    nb = model(64'h8);
`endif
    check("ovf_nblk", 512'(nb), 512'd1);
    e = exp_q.pop_front();
    check("ovf_blk_data", o_bdata, e.data);
    check("ovf_blk_last", {511'b0, o_blast}, {511'b0, e.last});
    o_ready = 1'b1;
    @(posedge clk); #1 o_ready = 1'b0;
    check("ovf_after_valid", {511'b0, o_bvalid}, 512'd0);
    check("ovf_after_err", {511'b0, o_err}, 512'd0);
    check("ovf_after_ready", {511'b0, o_inready}, 512'd1);

    repeat (3) @(posedge clk);
    check("sb_empty", 512'(exp_q.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
